// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// bus write-strobe codes, the line terminator that releases a line lock,
// and the round-robin distance helper used by rr_arbiter.
// No ports (package).
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    POLL  = 3'd2,
    GAP_P = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    GAP_D = 3'd6
  } arb_state_t;

  localparam logic [3:0] WSTRB_POLL = 4'b0000;
  localparam logic [3:0] WSTRB_BYTE = 4'b0001;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Number of steps from the last grant to requester idx, walking upward
  // and wrapping. The requester right after the last grant scores 0, the
  // last grant itself scores n-1, so lower means higher priority.
  function automatic logic [3:0] rr_distance(input int idx, input logic [2:0] last,
                                             input int n);
    int d;
    d = (idx + 2 * n - int'({29'b0, last}) - 1) % n;
    return 4'(d);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. The search starts at the
// requester after last_idx and wraps; the first active request wins.
// The pointer register lives in the parent.
// Ports:
//   req        in  N  request vector
//   last_idx   in  3  index of the previous grant
//   grant      out N  one-hot grant (all zero when nothing requested)
//   grant_idx  out 3  encoded grant index
//   grant_any  out 1  some request was granted
module rr_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last_idx,
  output logic [N-1:0] grant,
  output logic [2:0]   grant_idx,
  output logic         grant_any
);

  logic [3:0] best_dist;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    best_dist = 4'd8;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (rr_distance(i, last_idx, N) < best_dist)) begin
        best_dist = rr_distance(i, last_idx, N);
        grant_idx = 3'(i);
        grant_any = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (grant_any && (grant_idx == 3'(i))) begin
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one single-byte-buffered UART transmitter between NUM_REQ byte
// streams. Acts as bus master: polls the UART's buffer-empty flag, then
// writes the byte. With LOCK_ON_LINE=1 an owner keeps the grant until it
// sends a line feed or stays silent for LOCK_TIMEOUT clocks.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req_valid/req_data   per-requester byte (requester i on [8i+7:8i])
//   req_ready            one-clock pulse when requester i's byte is written
//   tx_enable            UART select, high exactly while tx_mem_valid is
//   tx_mem_valid/wstrb/wdata/addr  bus request (wstrb 0 = poll, 1 = write)
//   tx_mem_ready/rdata   registered UART response; rdata[0] = buffer empty
//   grant_id             current or last owner (debug)
//   busy                 high whenever the FSM is not IDLE
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int          NUM_REQ      = 4,
  parameter int          LOCK_ON_LINE = 1,
  parameter int          LOCK_TIMEOUT = 100000,
  parameter logic [31:0] TX_ADDR      = 32'h0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_enable,
  output logic                 tx_mem_valid,
  output logic [3:0]           tx_mem_wstrb,
  output logic [31:0]          tx_mem_wdata,
  output logic [31:0]          tx_mem_addr,
  input  logic                 tx_mem_ready,
  input  logic [31:0]          tx_mem_rdata,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  localparam logic [19:0] LOCK_LIMIT = 20'(LOCK_TIMEOUT - 1);

  arb_state_t         state;
  logic [7:0]         hold_byte;
  logic               buf_empty;
  logic               locked;
  logic [19:0]        lock_cnt;
  logic [2:0]         rr_next;

  logic [NUM_REQ-1:0] owner_mask;
  logic               owner_valid;
  logic [NUM_REQ-1:0] eligible;
  logic [2:0]         last_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic [2:0]         arb_idx;
  logic               arb_any;
  logic [7:0]         sel_byte;
  logic [2:0]         rr_after;

  logic               unused_rdata;
  assign unused_rdata = ^tx_mem_rdata[31:1];

  // rr_next is the first index to search, so resetting it to 0 lets
  // requester 0 win first; the picker wants the previous grant instead.
  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_mask[i] = (grant_id == 3'(i));
    end
    owner_valid = |(req_valid & owner_mask);
    eligible    = locked ? (req_valid & owner_mask) : req_valid;
    last_idx    = (rr_next == 3'd0) ? 3'(NUM_REQ - 1) : (rr_next - 3'd1);
  end

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req      (eligible),
    .last_idx (last_idx),
    .grant    (arb_grant),
    .grant_idx(arb_idx),
    .grant_any(arb_any)
  );

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_byte = req_data[8*i +: 8];
      end
    end
    rr_after = (arb_idx == 3'(NUM_REQ - 1)) ? 3'd0 : (arb_idx + 3'd1);
  end

  // Bus outputs are registered and change together with the state, so
  // valid is high exactly in POLL and WRITE. The GAP states hold valid low
  // for one clock so the UART's lingering registered ready is never
  // mistaken for the answer to the next request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      hold_byte    <= 8'h00;
      buf_empty    <= 1'b0;
      locked       <= 1'b0;
      lock_cnt     <= 20'd0;
      rr_next      <= 3'd0;
      req_ready    <= '0;
      tx_enable    <= 1'b0;
      tx_mem_valid <= 1'b0;
      tx_mem_wstrb <= 4'b0000;
      tx_mem_wdata <= 32'h0;
      tx_mem_addr  <= 32'h0;
      grant_id     <= 3'd0;
      busy         <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (locked) begin
            if (owner_valid) begin
              lock_cnt <= 20'd0;
              state    <= ARB;
              busy     <= 1'b1;
            end else if (lock_cnt == LOCK_LIMIT) begin
              locked   <= 1'b0;
              lock_cnt <= 20'd0;
            end else begin
              lock_cnt <= lock_cnt + 20'd1;
            end
          end else if (|req_valid) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          // A requester that withdrew before being latched just sends us
          // back to IDLE rather than starting an empty transfer.
          if (arb_any) begin
            hold_byte    <= sel_byte;
            grant_id     <= arb_idx;
            rr_next      <= rr_after;
            state        <= POLL;
            tx_enable    <= 1'b1;
            tx_mem_valid <= 1'b1;
            tx_mem_wstrb <= WSTRB_POLL;
            tx_mem_addr  <= TX_ADDR;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        POLL: begin
          if (tx_mem_ready) begin
            buf_empty    <= tx_mem_rdata[0];
            tx_enable    <= 1'b0;
            tx_mem_valid <= 1'b0;
            tx_mem_addr  <= 32'h0;
            state        <= GAP_P;
          end
        end
        GAP_P: begin
          tx_enable    <= 1'b1;
          tx_mem_valid <= 1'b1;
          tx_mem_addr  <= TX_ADDR;
          if (buf_empty) begin
            tx_mem_wstrb <= WSTRB_BYTE;
            tx_mem_wdata <= {24'h0, hold_byte};
            state        <= WRITE;
          end else begin
            tx_mem_wstrb <= WSTRB_POLL;
            state        <= POLL;
          end
        end
        WRITE: begin
          if (tx_mem_ready) begin
            tx_enable    <= 1'b0;
            tx_mem_valid <= 1'b0;
            tx_mem_wstrb <= WSTRB_POLL;
            tx_mem_wdata <= 32'h0;
            tx_mem_addr  <= 32'h0;
            req_ready    <= owner_mask;
            state        <= DONE;
          end
        end
        DONE: begin
          if (LOCK_ON_LINE != 0) begin
            locked <= (hold_byte != ASCII_LF);
          end
          lock_cnt <= 20'd0;
          state    <= GAP_D;
        end
        GAP_D: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Two arbiter instances: "a" with line locking (LOCK_TIMEOUT=16) and "b"
// without locking. Each has a small UART model whose ready is registered
// from valid. Stimulus pushes bytes into per-requester queues and the
// expected bus writes into a scoreboard; monitors pop and compare on
// every accepted write.
module tb_uart_tx_arbiter;

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
    int         polls;
  } exp_t;

  logic clk;
  logic resetn;

  logic [3:0]  req_valid_a, req_ready_a;
  logic [31:0] req_data_a;
  logic        tx_enable_a, tx_mem_valid_a, tx_mem_ready_a, busy_a;
  logic [3:0]  tx_mem_wstrb_a;
  logic [31:0] tx_mem_wdata_a, tx_mem_addr_a, tx_mem_rdata_a;
  logic [2:0]  grant_id_a;

  logic [3:0]  req_valid_b, req_ready_b;
  logic [31:0] req_data_b;
  logic        tx_enable_b, tx_mem_valid_b, tx_mem_ready_b, busy_b;
  logic [3:0]  tx_mem_wstrb_b;
  logic [31:0] tx_mem_wdata_b, tx_mem_addr_b, tx_mem_rdata_b;
  logic [2:0]  grant_id_b;

  int n_compared   = 0;
  int n_mismatched = 0;

  exp_t       exp_a[$];
  exp_t       exp_b[$];
  logic [7:0] feed_a[4][$];

  int   busy_target_a;
  int   polls_since_a;
  int   poll_cnt_a;
  logic prev_acc_a;
  logic [3:0] exp_ready_mask_a;

  uart_tx_arbiter #(
    .NUM_REQ(4), .LOCK_ON_LINE(1), .LOCK_TIMEOUT(16), .TX_ADDR(32'h1000_0000)
  ) dut_a (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid_a), .req_data(req_data_a), .req_ready(req_ready_a),
    .tx_enable(tx_enable_a), .tx_mem_valid(tx_mem_valid_a),
    .tx_mem_wstrb(tx_mem_wstrb_a), .tx_mem_wdata(tx_mem_wdata_a),
    .tx_mem_addr(tx_mem_addr_a), .tx_mem_ready(tx_mem_ready_a),
    .tx_mem_rdata(tx_mem_rdata_a), .grant_id(grant_id_a), .busy(busy_a)
  );

  uart_tx_arbiter #(
    .NUM_REQ(4), .LOCK_ON_LINE(0), .LOCK_TIMEOUT(16), .TX_ADDR(32'h1000_0000)
  ) dut_b (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid_b), .req_data(req_data_b), .req_ready(req_ready_b),
    .tx_enable(tx_enable_b), .tx_mem_valid(tx_mem_valid_b),
    .tx_mem_wstrb(tx_mem_wstrb_b), .tx_mem_wdata(tx_mem_wdata_b),
    .tx_mem_addr(tx_mem_addr_b), .tx_mem_ready(tx_mem_ready_b),
    .tx_mem_rdata(tx_mem_rdata_b), .grant_id(grant_id_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART models: ready is valid delayed by one clock, so it lingers one
  // clock after valid falls. Model "a" reports busy for busy_target_a
  // polls after each write.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_mem_ready_a <= 1'b0;
      polls_since_a  <= 0;
    end else begin
      tx_mem_ready_a <= tx_mem_valid_a && tx_enable_a;
      if (tx_mem_valid_a && tx_mem_ready_a) begin
        if (tx_mem_wstrb_a == 4'b0000) polls_since_a <= polls_since_a + 1;
        else polls_since_a <= 0;
      end
    end
  end
  assign tx_mem_rdata_a = {31'h0, (polls_since_a >= busy_target_a)};

  always @(posedge clk or negedge resetn) begin
    if (!resetn) tx_mem_ready_b <= 1'b0;
    else tx_mem_ready_b <= tx_mem_valid_b && tx_enable_b;
  end
  assign tx_mem_rdata_b = 32'h1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] data, input int polls);
    exp_t e;
    e.id    = 3'(id);
    e.data  = data;
    e.polls = polls;
    feed_a[id].push_back(data);
    exp_a.push_back(e);
  endtask

  task automatic waitReady(input int id, input int budget, output int cycles);
    cycles = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (req_ready_a[id]) begin
        cycles = c;
        break;
      end
    end
    if (cycles == 0) checkOutput("req_ready_timeout", 64'(0), 64'(1));
  endtask

  task automatic waitIdle(input int budget);
    int done;
    done = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy_a) begin
        done = 1;
        break;
      end
    end
    if (done == 0) checkOutput("idle_timeout", 64'(0), 64'(1));
  endtask

  // Requester models for instance "a": present the head of each queue and
  // retire it when its req_ready pulse is seen.
  initial begin
    req_valid_a = '0;
    req_data_a  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (resetn && req_ready_a[i] && (feed_a[i].size() > 0)) void'(feed_a[i].pop_front());
        if (feed_a[i].size() > 0) begin
          req_valid_a[i]        = 1'b1;
          req_data_a[8*i +: 8]  = feed_a[i][0];
        end else begin
          req_valid_a[i]        = 1'b0;
          req_data_a[8*i +: 8]  = 8'h00;
        end
      end
    end
  end

  // Monitor "a": every accepted poll/write is checked; the clock after an
  // accept must be idle on the bus, and req_ready must match the owner of
  // the last write exactly once.
  initial begin
    exp_t e;
    poll_cnt_a       = 0;
    prev_acc_a       = 1'b0;
    exp_ready_mask_a = 4'b0000;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        poll_cnt_a       = 0;
        prev_acc_a       = 1'b0;
        exp_ready_mask_a = 4'b0000;
      end else begin
        if (prev_acc_a) checkOutput("gap_idle", 64'(tx_mem_valid_a), 64'(0));
        prev_acc_a = tx_mem_valid_a && tx_mem_ready_a;
        if (prev_acc_a) begin
          checkOutput("tx_addr", 64'(tx_mem_addr_a), 64'(32'h1000_0000));
          checkOutput("tx_enable", 64'(tx_enable_a), 64'(1));
          if (tx_mem_wstrb_a == 4'b0000) begin
            poll_cnt_a++;
          end else if (exp_a.size() == 0) begin
            checkOutput("unexpected_write", 64'(1), 64'(0));
          end else begin
            e = exp_a.pop_front();
            checkOutput("wstrb", 64'(tx_mem_wstrb_a), 64'(4'b0001));
            checkOutput("wdata", 64'(tx_mem_wdata_a), 64'({24'h0, e.data}));
            checkOutput("grant_id", 64'(grant_id_a), 64'(e.id));
            checkOutput("poll_count", 64'(poll_cnt_a), 64'(e.polls));
            exp_ready_mask_a = 4'b0001 << e.id;
            poll_cnt_a = 0;
          end
        end
        if (req_ready_a != 4'b0000) begin
          checkOutput("req_ready_a", 64'(req_ready_a), 64'(exp_ready_mask_a));
          exp_ready_mask_a = 4'b0000;
        end
      end
    end
  end

  // Monitor "b": write order and data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && tx_mem_valid_b && tx_mem_ready_b && (tx_mem_wstrb_b == 4'b0001)) begin
        if (exp_b.size() == 0) begin
          checkOutput("b_unexpected_write", 64'(1), 64'(0));
        end else begin
          e = exp_b.pop_front();
          checkOutput("b_grant_id", 64'(grant_id_b), 64'(e.id));
          checkOutput("b_wdata", 64'(tx_mem_wdata_b), 64'({24'h0, e.data}));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int pulses;
    exp_t e;
    resetn        = 1'b0;
    busy_target_a = 0;
    req_valid_b   = 4'b0000;
    req_data_b    = 32'h0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 64'(tx_mem_valid_a), 64'(0));
    checkOutput("rst_enable", 64'(tx_enable_a), 64'(0));
    checkOutput("rst_wstrb", 64'(tx_mem_wstrb_a), 64'(0));
    checkOutput("rst_wdata", 64'(tx_mem_wdata_a), 64'(0));
    checkOutput("rst_addr", 64'(tx_mem_addr_a), 64'(0));
    checkOutput("rst_req_ready", 64'(req_ready_a), 64'(0));
    checkOutput("rst_grant_id", 64'(grant_id_a), 64'(0));
    checkOutput("rst_busy", 64'(busy_a), 64'(0));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // No locking, all four requesters continuously valid: 0,1,2,3,0,1,2,3
    $display("[TB] round robin without lock");
    req_data_b = 32'hD3C2B1A0;
    for (int i = 0; i < 8; i++) begin
      e.id    = 3'(i % 4);
      e.data  = 8'hA0 + 8'(8'h11 * (i % 4));
      e.polls = 1;
      exp_b.push_back(e);
    end
    req_valid_b = 4'b1111;
    pulses = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (req_ready_b != 4'b0000) pulses++;
      if (pulses == 8) break;
    end
    req_valid_b = 4'b0000;
    checkOutput("b_pulses", 64'(pulses), 64'(8));
    repeat (4) @(negedge clk);

    // Single byte, empty UART: cycle-by-cycle bus view
    $display("[TB] single byte latency");
    @(posedge clk); #2;
    applyStimulus(0, 8'h41, 1);
    @(negedge clk);
    for (cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc == 1) checkOutput("lat_busy", 64'(busy_a), 64'(1));
      if (cyc == 3) begin
        checkOutput("lat_poll_valid", 64'(tx_mem_valid_a), 64'(1));
        checkOutput("lat_poll_wstrb", 64'(tx_mem_wstrb_a), 64'(4'b0000));
      end
      if (cyc == 4) checkOutput("lat_gap_p", 64'(tx_mem_valid_a), 64'(0));
      if (cyc == 5) begin
        checkOutput("lat_write_valid", 64'(tx_mem_valid_a), 64'(1));
        checkOutput("lat_write_wstrb", 64'(tx_mem_wstrb_a), 64'(4'b0001));
        checkOutput("lat_write_wdata", 64'(tx_mem_wdata_a), 64'(32'h41));
      end
      if (cyc == 7) checkOutput("lat_req_ready", 64'(req_ready_a), 64'(4'b0001));
    end
    waitIdle(20);

    // UART busy for three polls; line feed also clears the lock on 0
    $display("[TB] polling until empty");
    busy_target_a = 3;
    @(posedge clk); #2;
    applyStimulus(0, 8'h0A, 4);
    waitReady(0, 200, cyc);
    waitIdle(20);
    busy_target_a = 0;

    // Requester 1 keeps its line "ab\n" together while 2 waits
    $display("[TB] line lock");
    @(posedge clk); #2;
    applyStimulus(1, 8'h61, 1);
    applyStimulus(1, 8'h62, 1);
    applyStimulus(1, 8'h0A, 1);
    applyStimulus(2, 8'h0A, 1);
    waitReady(2, 300, cyc);
    waitIdle(20);

    // Owner 1 goes quiet while locked; 3 gets in after the timeout
    $display("[TB] lock timeout");
    @(posedge clk); #2;
    applyStimulus(1, 8'h61, 1);
    waitReady(1, 100, cyc);
    applyStimulus(3, 8'h0A, 1);
    waitReady(3, 100, cyc);
    checkOutput("timeout_gap", 64'(cyc), 64'(25));
    waitIdle(20);

    // Reset in the middle of a write
    $display("[TB] reset during write");
    @(posedge clk); #2;
    applyStimulus(0, 8'h55, 1);
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_mem_valid_a && (tx_mem_wstrb_a == 4'b0001)) begin
        pulses = 1;
        break;
      end
    end
    checkOutput("reached_write", 64'(pulses), 64'(1));
    resetn = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(tx_mem_valid_a), 64'(0));
    checkOutput("arst_enable", 64'(tx_enable_a), 64'(0));
    checkOutput("arst_wstrb", 64'(tx_mem_wstrb_a), 64'(0));
    checkOutput("arst_wdata", 64'(tx_mem_wdata_a), 64'(0));
    checkOutput("arst_addr", 64'(tx_mem_addr_a), 64'(0));
    checkOutput("arst_busy", 64'(busy_a), 64'(0));
    checkOutput("arst_req_ready", 64'(req_ready_a), 64'(0));
    repeat (2) @(negedge clk);
    checkOutput("arst_req_ready_hold", 64'(req_ready_a), 64'(0));
    resetn = 1'b1;
    waitReady(0, 100, cyc);
    checkOutput("restart_latency", 64'(cyc), 64'(7));
    waitIdle(20);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_a_empty", 64'(exp_a.size()), 64'(0));
    checkOutput("scoreboard_b_empty", 64'(exp_b.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
